// File: rtl/free_list_pkg.sv
// Shared rename-path types: physical register index, superscalar width and
// the free-list pointer type that the branch stack checkpoints.
package free_list_pkg;

    localparam int PHYS_REG_SZ_R10K = 64;
    localparam int N                = 4;
    localparam int NUM_SCALAR_BITS  = $clog2(N + 1);
    localparam int PHYS_REG_IDX_W   = $clog2(PHYS_REG_SZ_R10K);
    localparam int FL_SZ_DEF        = PHYS_REG_SZ_R10K - 32;
    localparam int FL_PTR_BITS_DEF  = $clog2(FL_SZ_DEF);

    typedef logic [PHYS_REG_IDX_W-1:0]  PHYS_REG_IDX;
    typedef logic [FL_PTR_BITS_DEF:0]   FREE_LIST_PTR;

endpackage

// File: rtl/free_list_checker.sv
// Occupancy bitmap that flags double frees, frees of register 0 and
// over-allocation; the bitmap is rebuilt from the live region after a restore.
module free_list_checker
    import free_list_pkg::*;
#(
    parameter int FL_SZ       = PHYS_REG_SZ_R10K - 32,
    parameter int FL_PTR_BITS = $clog2(FL_SZ)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_SCALAR_BITS-1:0]  num_retiring,
    input  PHYS_REG_IDX [N-1:0]         phys_regs_retiring,
    input  logic [NUM_SCALAR_BITS-1:0]  num_dispatching,
    input  PHYS_REG_IDX [N-1:0]         regs_to_use,
    input  logic                        restore_valid,
    input  logic [FL_PTR_BITS:0]        head,
    input  logic [FL_PTR_BITS:0]        free_count,
    input  PHYS_REG_IDX [FL_SZ-1:0]     entries,
    output logic                        fl_error
);
    localparam int MAP_W = FL_SZ + 32;
    localparam logic [MAP_W-1:0] INIT_MAP = {{FL_SZ{1'b1}}, 32'b0};

    typedef logic [FL_PTR_BITS:0]   ptr_t;
    typedef logic [FL_PTR_BITS-1:0] idx_t;

    logic [MAP_W-1:0] free_map;
    logic [MAP_W-1:0] live_map;
    logic [MAP_W-1:0] map_next;
    logic             rebuild;
    logic             err_next;

    // An entry is live when its ring offset from head is below free_count.
    always_comb begin
        live_map = '0;
        for (int k = 0; k < FL_SZ; k++) begin
            if (ptr_t'(idx_t'(ptr_t'(k) - head)) < free_count)
                live_map[entries[k]] = 1'b1;
        end
    end

    always_comb begin
        map_next = rebuild ? live_map : free_map;
        err_next = 1'b0;
        if (!restore_valid) begin
            if (ptr_t'(num_dispatching) > free_count)
                err_next = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (NUM_SCALAR_BITS'(i) < num_dispatching)
                    map_next[regs_to_use[i]] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (NUM_SCALAR_BITS'(i) < num_retiring) begin
                if (phys_regs_retiring[i] == '0 || map_next[phys_regs_retiring[i]])
                    err_next = 1'b1;
                map_next[phys_regs_retiring[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            free_map <= INIT_MAP;
            rebuild  <= 1'b0;
            fl_error <= 1'b0;
        end else begin
            free_map <= map_next;
            rebuild  <= restore_valid;
            fl_error <= fl_error | err_next;
        end
    end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers for R10K rename: retire frees at
// tail, dispatch allocates at head. Define FREE_LIST_CHECK_EN for the checker.
module free_list
    import free_list_pkg::*;
#(
    parameter int FL_SZ       = PHYS_REG_SZ_R10K - 32,
    parameter int FL_PTR_BITS = $clog2(FL_SZ)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_SCALAR_BITS-1:0]  num_retiring,
    input  PHYS_REG_IDX [N-1:0]         phys_regs_retiring,
    input  logic [NUM_SCALAR_BITS-1:0]  num_dispatching,
    output PHYS_REG_IDX [N-1:0]         regs_to_use,
    output logic [FL_PTR_BITS:0]        free_count,
    output logic [FL_PTR_BITS:0]        head_snapshot,
    input  logic                        restore_valid,
    input  logic [FL_PTR_BITS:0]        restore_head,
    output logic                        fl_error
);
    typedef logic [FL_PTR_BITS:0]   ptr_t;
    typedef logic [FL_PTR_BITS-1:0] idx_t;

    PHYS_REG_IDX [FL_SZ-1:0] entries;
    ptr_t head;
    ptr_t tail;
    ptr_t head_next;
    ptr_t tail_next;

    // Frees are older than any mispredicted branch, so tail never rolls back.
    always_comb begin
        head_next = restore_valid ? restore_head : head + ptr_t'(num_dispatching);
        tail_next = tail + ptr_t'(num_retiring);
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            regs_to_use[i] = entries[idx_t'(head + ptr_t'(i))];
    end

    assign head_snapshot = head;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= ptr_t'(FL_SZ);
            free_count <= ptr_t'(FL_SZ);
            for (int k = 0; k < FL_SZ; k++)
                entries[k] <= PHYS_REG_IDX'(32 + k);
        end else begin
            head       <= head_next;
            tail       <= tail_next;
            free_count <= tail_next - head_next;
            for (int i = 0; i < N; i++) begin
                if (NUM_SCALAR_BITS'(i) < num_retiring)
                    entries[idx_t'(tail + ptr_t'(i))] <= phys_regs_retiring[i];
            end
        end
    end

`ifdef FREE_LIST_CHECK_EN
    free_list_checker #(
        .FL_SZ       (FL_SZ),
        .FL_PTR_BITS (FL_PTR_BITS)
    ) u_checker (
        .clock              (clock),
        .reset              (reset),
        .num_retiring       (num_retiring),
        .phys_regs_retiring (phys_regs_retiring),
        .num_dispatching    (num_dispatching),
        .regs_to_use        (regs_to_use),
        .restore_valid      (restore_valid),
        .head               (head),
        .free_count         (free_count),
        .entries            (entries),
        .fl_error           (fl_error)
    );
`else
    assign fl_error = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: the model is an unbounded stream of every
// register ever placed in the list plus an absolute allocation pointer.
`timescale 1ns/1ps
module tb_free_list;
    import free_list_pkg::*;

    localparam int FL_SZ = PHYS_REG_SZ_R10K - 32;
`ifdef FREE_LIST_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef PHYS_REG_IDX [N-1:0] slots_t;

    logic                       clock = 1'b0;
    logic                       reset = 1'b0;
    logic [NUM_SCALAR_BITS-1:0] num_retiring;
    logic [NUM_SCALAR_BITS-1:0] num_dispatching;
    slots_t                     phys_regs_retiring;
    slots_t                     regs_to_use;
    FREE_LIST_PTR               free_count;
    FREE_LIST_PTR               head_snapshot;
    FREE_LIST_PTR               restore_head;
    logic                       restore_valid;
    logic                       fl_error;

    free_list dut (
        .clock              (clock),
        .reset              (reset),
        .num_retiring       (num_retiring),
        .phys_regs_retiring (phys_regs_retiring),
        .num_dispatching    (num_dispatching),
        .regs_to_use        (regs_to_use),
        .free_count         (free_count),
        .head_snapshot      (head_snapshot),
        .restore_valid      (restore_valid),
        .restore_head       (restore_head),
        .fl_error           (fl_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int     fc;
        int     hd;
        slots_t regs;
        bit     err;
    } exp_t;

    exp_t exp_q[$];
    int   stream[$];
    int   alloc_ptr;
    bit   model_err;
    bit   snap_on;
    int   snap_abs;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic bit in_free(input int v, input int from);
        for (int j = from; j < stream.size(); j++)
            if (stream[j] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic slots_t mk(input int a, input int b, input int c, input int d);
        slots_t s;
        s[0] = PHYS_REG_IDX'(a);
        s[1] = PHYS_REG_IDX'(b);
        s[2] = PHYS_REG_IDX'(c);
        s[3] = PHYS_REG_IDX'(d);
        return s;
    endfunction

    task automatic model_reset();
        stream.delete();
        for (int k = 0; k < FL_SZ; k++) stream.push_back(32 + k);
        alloc_ptr = 0;
        model_err = 1'b0;
        snap_on   = 1'b0;
    endtask

    task automatic push_expect();
        exp_t e;
        e.fc  = stream.size() - alloc_ptr;
        e.hd  = alloc_ptr % (2 * FL_SZ);
        e.err = model_err;
        for (int i = 0; i < N; i++)
            e.regs[i] = (alloc_ptr + i < stream.size()) ? PHYS_REG_IDX'(stream[alloc_ptr + i]) : '0;
        exp_q.push_back(e);
    endtask

    task automatic step(input int nd, input int nr, input slots_t fr, input bit rv, input int rabs);
        int new_alloc;
        @(negedge clock);
        num_dispatching    = NUM_SCALAR_BITS'(nd);
        num_retiring       = NUM_SCALAR_BITS'(nr);
        phys_regs_retiring = fr;
        restore_valid      = rv;
        restore_head       = rv ? FREE_LIST_PTR'(rabs) : FREE_LIST_PTR'($urandom);
        if (!rv && nd > stream.size() - alloc_ptr) model_err |= CHECK_EN;
        new_alloc = rv ? rabs : alloc_ptr + nd;
        for (int i = 0; i < nr; i++) begin
            if (fr[i] == 0 || in_free(int'(fr[i]), new_alloc)) model_err |= CHECK_EN;
            stream.push_back(int'(fr[i]));
        end
        alloc_ptr = new_alloc;
        push_expect();
    endtask

    task automatic idle_inputs();
        num_dispatching    = '0;
        num_retiring       = '0;
        phys_regs_retiring = '0;
        restore_valid      = 1'b0;
        restore_head       = '0;
    endtask

    task automatic check_reset_state();
        check("rst free_count", free_count, FL_SZ);
        check("rst head_snapshot", head_snapshot, 0);
        check("rst fl_error", fl_error, 0);
        for (int i = 0; i < N; i++)
            check($sformatf("rst regs_to_use[%0d]", i), regs_to_use[i], 32 + i);
    endtask

    // Asynchronous reset applied mid-cycle, away from any edge.
    task automatic async_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_reset_state();
        idle_inputs();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic random_step();
        int     cnt, low, room, nd, nr, idx;
        bit     rv;
        int     cand[$];
        slots_t fr;
        if (!snap_on && $urandom_range(0, 7) == 0) begin
            snap_on  = 1'b1;
            snap_abs = alloc_ptr;
        end else if (snap_on && $urandom_range(0, 11) == 0) begin
            snap_on = 1'b0;
        end
        cnt  = stream.size() - alloc_ptr;
        low  = snap_on ? snap_abs : alloc_ptr;
        rv   = snap_on && ($urandom_range(0, 5) == 0);
        nd   = rv ? $urandom_range(0, N) : $urandom_range(0, (cnt < N) ? cnt : N);
        room = FL_SZ - (stream.size() - low);
        nr   = $urandom_range(0, (room < N) ? room : N);
        for (int v = 1; v < PHYS_REG_SZ_R10K; v++)
            if (!in_free(v, low)) cand.push_back(v);
        for (int i = 0; i < N; i++) begin
            if (i < nr) begin
                idx   = $urandom_range(0, cand.size() - 1);
                fr[i] = PHYS_REG_IDX'(cand[idx]);
                cand.delete(idx);
            end else begin
                fr[i] = PHYS_REG_IDX'($urandom);
            end
        end
        step(nd, nr, fr, rv, snap_abs);
        if (rv) snap_on = 1'b0;
    endtask

    // Monitor: the list presents fresh state after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("free_count", free_count, e.fc);
                check("head_snapshot", head_snapshot, e.hd);
                check("fl_error", fl_error, int'(e.err));
                for (int i = 0; i < N; i++)
                    if (i < e.fc)
                        check($sformatf("regs_to_use[%0d]", i), regs_to_use[i], int'(e.regs[i]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int h;
        idle_inputs();
        model_reset();
        #12;
        check_reset_state();
        @(negedge clock);
        reset = 1'b1;

        step(0, 0, mk(0, 0, 0, 0), 1'b0, 0);
        for (int c = 0; c < FL_SZ / N; c++)
            step(N, 0, mk(1, 2, 3, 4), 1'b0, 0);

        step(0, 2, mk(5, 9, 0, 0), 1'b0, 0);
        step(0, 4, mk(32, 33, 34, 35), 1'b0, 0);
        step(0, 4, mk(36, 37, 38, 39), 1'b0, 0);
        step(2, 3, mk(40, 41, 42, 0), 1'b0, 0);

        h = alloc_ptr;
        for (int c = 0; c < 3; c++)
            step(2, 0, mk(0, 0, 0, 0), 1'b0, 0);
        step(3, 1, mk(43, 0, 0, 0), 1'b1, h);
        for (int c = 0; c < 3; c++)
            step(4, 0, mk(0, 0, 0, 0), 1'b0, 0);

        for (int c = 0; c < 400; c++)
            random_step();

        async_reset();

        step(2, 0, mk(0, 0, 0, 0), 1'b0, 0);
        step(0, 1, mk(40, 0, 0, 0), 1'b0, 0);
        step(0, 0, mk(0, 0, 0, 0), 1'b0, 0);
        step(0, 0, mk(0, 0, 0, 0), 1'b0, 0);
        async_reset();
        step(1, 0, mk(0, 0, 0, 0), 1'b0, 0);
        step(0, 1, mk(0, 0, 0, 0), 1'b0, 0);
        step(0, 0, mk(0, 0, 0, 0), 1'b0, 0);
        async_reset();

        @(posedge clock);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
